// File: rtl/minterm_sweeper.sv
// Steps a 4-input function block through all 16 input vectors, waits a settle time on each,
// and captures f_p into a truth table and a ones count. done pulses for one cycle at the end.
module minterm_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f_p,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  ones_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam state_t     LOAD_ST   = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] tt_q;
    logic [4:0]  oc_q;

    // idx_q is forced to 0 whenever the sweep is not running, so it drives a..d directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= 16'd0;
            oc_q    <= 5'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        tt_q    <= 16'd0;
                        oc_q    <= 5'd0;
                        idx_q   <= 4'd0;
                        cnt_q   <= SETTLE_LD;
                        busy_q  <= 1'b1;
                        state_q <= LOAD_ST;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        idx_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        idx_q   <= 4'd0;
                    end else begin
                        tt_q[idx_q] <= f_p;
                        oc_q        <= oc_q + {4'd0, f_p};
                        if (idx_q == 4'd15) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            idx_q   <= 4'd0;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            cnt_q   <= SETTLE_LD;
                            state_q <= LOAD_ST;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= 4'd0;
                end
            endcase
        end
    end

    assign {a, b, c, d}  = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign truth_table   = tt_q;
    assign ones_count    = oc_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Scoreboard bench: three sweepers (settle 1, 0, 3) driven by behavioural function models.
module tb_minterm_sweeper;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  oc;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_w [3];
    logic        abort_w [3];
    logic        fp_w    [3];
    logic        a_w     [3];
    logic        b_w     [3];
    logic        c_w     [3];
    logic        d_w     [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic [15:0] tt_w    [3];
    logic [4:0]  oc_w    [3];
    int          mode    [3];

    int   checks;
    int   errors;
    exp_t sb [$];

    // 0: scenario-1 function, 1: const 1, 2: const 0, 3: f_p = d
    function automatic logic model_f(input int m, input logic [3:0] v);
        case (m)
            0:       model_f = !(v inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd10, 4'd12, 4'd14});
            1:       model_f = 1'b1;
            2:       model_f = 1'b0;
            default: model_f = v[0];
        endcase
    endfunction

    function automatic int settle_of(input int i);
        settle_of = (i == 0) ? 1 : (i == 1) ? 0 : 3;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        minterm_sweeper #(.SETTLE_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start_w[g]),
            .abort       (abort_w[g]),
            .f_p         (fp_w[g]),
            .a           (a_w[g]),
            .b           (b_w[g]),
            .c           (c_w[g]),
            .d           (d_w[g]),
            .busy        (busy_w[g]),
            .done        (done_w[g]),
            .truth_table (tt_w[g]),
            .ones_count  (oc_w[g])
        );
        assign fp_w[g] = model_f(mode[g], {a_w[g], b_w[g], c_w[g], d_w[g]});
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] vec(input int i);
        vec = {a_w[i], b_w[i], c_w[i], d_w[i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk({tag, " vec"},  32'(vec(i)),     32'd0);
        chk({tag, " busy"}, 32'(busy_w[i]),  32'd0);
        chk({tag, " done"}, 32'(done_w[i]),  32'd0);
        chk({tag, " tt"},   32'(tt_w[i]),    32'd0);
        chk({tag, " oc"},   32'(oc_w[i]),    32'd0);
    endtask

    // One sweep; vector/busy/done-count deviations are tallied per edge, results go via the scoreboard.
    task automatic sweep(input int i, input int m, input logic [15:0] ett, input logic [4:0] eoc,
                         input int abort_idx, input bit repulse, input string tag);
        int         s, dur, lat, bad, abort_e;
        bit         seen7;
        logic [3:0] v, expv;
        logic       expb;
        exp_t       e;
        s   = settle_of(i);
        dur = 16 * (s + 1);
        mode[i] = m;
        sb.push_back('{ett, eoc, (abort_idx >= 0) ? 0 : dur});
        @(negedge clk);
        start_w[i] = 1'b1;
        @(negedge clk);
        start_w[i] = 1'b0;
        lat = 0; bad = 0; abort_e = 0; seen7 = 1'b0;
        for (int ed = 1; ed <= dur + 8; ed++) begin
            @(negedge clk);
            abort_w[i] = 1'b0;
            start_w[i] = 1'b0;
            v    = vec(i);
            expv = (abort_e != 0 && ed >= abort_e) ? 4'd0 : (ed < dur) ? 4'(ed / (s + 1)) : 4'd0;
            expb = (abort_e == 0 || ed < abort_e) && (ed < dur);
            if (v !== expv) bad++;
            if (busy_w[i] !== expb) bad++;
            if (done_w[i] === 1'b1) begin
                if (lat == 0) lat = ed;
                else bad++;
            end
            if (abort_idx >= 0 && abort_e == 0 && v == 4'(abort_idx)) begin
                abort_w[i] = 1'b1;
                abort_e    = ed + 1;
            end
            if (repulse && v == 4'd7 && !seen7) begin
                seen7      = 1'b1;
                start_w[i] = 1'b1;
            end
            if (repulse && done_w[i] === 1'b1) start_w[i] = 1'b1;
        end
        start_w[i] = 1'b0;
        abort_w[i] = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, " tt"},     32'(tt_w[i]), 32'(e.tt));
            chk({tag, " oc"},     32'(oc_w[i]), 32'(e.oc));
            chk({tag, " done_at"}, 32'(lat),    32'(e.lat));
        end
        chk({tag, " seq"}, 32'(bad), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_w[i] = 1'b0;
            abort_w[i] = 1'b0;
            mode[i]    = 0;
        end
        repeat (3) @(negedge clk);
        chk_idle(0, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        // abort beats start in IDLE
        start_w[0] = 1'b1;
        abort_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        abort_w[0] = 1'b0;
        chk("abort_start busy", 32'(busy_w[0]), 32'd0);
        @(negedge clk);
        chk("abort_start vec", 32'(vec(0)), 32'd0);

        sweep(0, 0, 16'hAAE0, 5'd7,  -1, 1'b0, "s1");
        sweep(1, 1, 16'hFFFF, 5'd16, -1, 1'b0, "s2_ones");
        sweep(1, 2, 16'h0000, 5'd0,  -1, 1'b0, "s2_zeros");
        sweep(2, 3, 16'hAAAA, 5'd8,  -1, 1'b0, "s3");
        sweep(0, 1, 16'h001F, 5'd5,   5, 1'b0, "s4_abort");
        sweep(0, 0, 16'hAAE0, 5'd7,  -1, 1'b1, "s5_repulse");

        // asynchronous reset in the SAMPLE cycle of vector 3
        mode[0] = 1;
        @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("s6 pre oc",  32'(oc_w[0]), 32'd3);
        chk("s6 pre vec", 32'(vec(0)),  32'd3);
        #1 rst_n = 1'b0;
        #1 chk_idle(0, "s6 async");
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 0, 16'hAAE0, 5'd7, -1, 1'b0, "s6_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
